score_digits_display: RTL

Upstream feeder for the per-digit number bitmap stage in the video unit. It converts a binary game score into four decimal digits with a sequential double-dabble converter. For each screen pixel it decides which digit slot, if any, the pixel falls in. It then emits the in-slot offsets, the inside flag and the digit value that the bitmap stage consumes.

---
 rtl/score_digits_display_pkg.sv | 22 ++
 rtl/score_digits_display_bin2bcd_seq.sv | 104 ++++++++++
 rtl/score_digits_display.sv | 132 +++++++++++++
 3 files changed

// File: rtl/score_digits_display_pkg.sv
// Shared types and defaults for the score digit display and the number bitmap stage.
// Slot 0 holds the most significant digit, which is element [3] of a bcd4_t.
package score_digits_display_pkg;

    localparam int COORD_W     = 11;
    localparam int REL_W       = COORD_W + 1;
    localparam int SCORE_W     = 14;
    localparam int DIGIT_W_DEF = 6;
    localparam int DIGIT_H_DEF = 10;

    typedef logic [COORD_W-1:0] coordinate;

    // Element [3] holds the thousands digit and element [0] the units digit.
    typedef logic [3:0][3:0] bcd4_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

endpackage

// File: rtl/score_digits_display_bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep pending slot for scores
// that arrive mid-conversion. The newest pending score always wins.
module bin2bcd_seq
    import score_digits_display_pkg::*;
#(
    parameter int SCORE_MAX = 9999
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output bcd4_t              bcd_out,
    output logic               bcd_commit
);

    conv_state_t        r_state, w_state_next;
    logic [SCORE_W-1:0] r_bin, w_bin_next;
    logic [15:0]        r_bcd, w_bcd_next;
    logic [3:0]         r_cnt, w_cnt_next;
    logic               r_pending, w_pending_next;
    logic [SCORE_W-1:0] r_pend_score, w_pend_score_next;

    logic [SCORE_W-1:0] w_sat;
    logic [15:0]        w_adj;

    assign w_sat = (score > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                                 : r_bcd[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ST_IDLE;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_pend_score <= '0;
        end else begin
            r_state      <= w_state_next;
            r_bin        <= w_bin_next;
            r_bcd        <= w_bcd_next;
            r_cnt        <= w_cnt_next;
            r_pending    <= w_pending_next;
            r_pend_score <= w_pend_score_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_bin_next        = r_bin;
        w_bcd_next        = r_bcd;
        w_cnt_next        = r_cnt;
        w_pending_next    = r_pending;
        w_pend_score_next = r_pend_score;
        unique case (r_state)
            ST_IDLE: begin
                if (score_valid) begin
                    w_bin_next   = w_sat;
                    w_bcd_next   = '0;
                    w_cnt_next   = 4'd13;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_bcd_next = {w_adj[14:0], r_bin[SCORE_W-1]};
                w_bin_next = {r_bin[SCORE_W-2:0], 1'b0};
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_COMMIT;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
                if (score_valid) begin
                    w_pending_next    = 1'b1;
                    w_pend_score_next = w_sat;
                end
            end
            ST_COMMIT: begin
                // A pulse landing on the commit cycle is newer than any pending score.
                if (score_valid || r_pending) begin
                    w_bin_next     = score_valid ? w_sat : r_pend_score;
                    w_bcd_next     = '0;
                    w_cnt_next     = 4'd13;
                    w_pending_next = 1'b0;
                    w_state_next   = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign busy       = (r_state != ST_IDLE);
    assign bcd_commit = (r_state == ST_COMMIT);
    assign bcd_out    = bcd4_t'(r_bcd);

endmodule

// File: rtl/score_digits_display.sv
// Score display front end: BCD conversion plus per-pixel slot decode, producing
// registered offsets, inside flag and digit value for the number bitmap stage.
module score_digits_display
    import score_digits_display_pkg::*;
#(
    parameter int TOP_LEFT_X    = 16,
    parameter int TOP_LEFT_Y    = 8,
    parameter int DIGIT_W       = DIGIT_W_DEF,
    parameter int DIGIT_H       = DIGIT_H_DEF,
    parameter int DIGIT_GAP     = 2,
    parameter int BLANK_LEADING = 1,
    parameter int SCORE_MAX     = 9999
) (
    input  logic               clk,
    input  logic               resetN,
    input  coordinate          pixelX,
    input  coordinate          pixelY,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output coordinate          offsetX,
    output coordinate          offsetY,
    output logic               InsideRectangle,
    output logic [3:0]         digit
);

    localparam int PITCH = DIGIT_W + DIGIT_GAP;
    localparam logic signed [REL_W-1:0] H_LAST = REL_W'(DIGIT_H - 1);

    bcd4_t     w_bcd_out;
    logic      w_bcd_commit;
    bcd4_t     r_display;

    logic signed [REL_W-1:0] w_rel_x, w_rel_y;
    logic                    w_y_in;
    logic [3:0]              w_hit;
    logic [3:0]              w_blank;
    logic [2:0]              w_lead_zero;
    logic [3:0]              w_slot_digit [4];
    coordinate               w_off_x [4];

    logic      w_inside;
    logic [3:0] w_digit;
    coordinate w_off_x_sel, w_off_y_sel;

    logic      r_inside;
    logic [3:0] r_digit;
    coordinate r_off_x, r_off_y;

    bin2bcd_seq #(
        .SCORE_MAX (SCORE_MAX)
    ) u_bin2bcd (
        .clk         (clk),
        .resetN      (resetN),
        .score       (score),
        .score_valid (score_valid),
        .busy        (busy),
        .bcd_out     (w_bcd_out),
        .bcd_commit  (w_bcd_commit)
    );

    assign w_rel_x = $signed({1'b0, pixelX}) - $signed(REL_W'(TOP_LEFT_X));
    assign w_rel_y = $signed({1'b0, pixelY}) - $signed(REL_W'(TOP_LEFT_Y));
    assign w_y_in  = !w_rel_y[REL_W-1] && (w_rel_y <= H_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            localparam logic signed [REL_W-1:0] SLOT_LO = REL_W'(gi * PITCH);
            localparam logic signed [REL_W-1:0] SLOT_HI = REL_W'(gi * PITCH + DIGIT_W - 1);
            logic signed [REL_W-1:0] w_diff;

            assign w_slot_digit[gi] = r_display[3-gi];
            assign w_diff           = w_rel_x - SLOT_LO;
            assign w_off_x[gi]      = w_diff[COORD_W-1:0];

            // A slot is blank while it and every more significant digit are zero.
            if (gi < 3) begin : g_blank
                if (gi == 0) begin : g_first
                    assign w_lead_zero[gi] = (w_slot_digit[gi] == 4'd0);
                end else begin : g_rest
                    assign w_lead_zero[gi] = w_lead_zero[gi-1] && (w_slot_digit[gi] == 4'd0);
                end
                assign w_blank[gi] = (BLANK_LEADING != 0) && w_lead_zero[gi];
            end else begin : g_units
                assign w_blank[gi] = 1'b0;
            end

            assign w_hit[gi] = w_y_in && (w_rel_x >= SLOT_LO) && (w_rel_x <= SLOT_HI)
                               && !w_blank[gi];
        end
    endgenerate

    always_comb begin
        w_inside    = 1'b0;
        w_digit     = 4'd0;
        w_off_x_sel = '0;
        w_off_y_sel = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_hit[k]) begin
                w_inside    = 1'b1;
                w_digit     = w_slot_digit[k];
                w_off_x_sel = w_off_x[k];
                w_off_y_sel = w_rel_y[COORD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_display <= '0;
            r_inside  <= 1'b0;
            r_digit   <= 4'd0;
            r_off_x   <= '0;
            r_off_y   <= '0;
        end else begin
            if (w_bcd_commit) begin
                r_display <= w_bcd_out;
            end
            r_inside <= w_inside;
            r_digit  <= w_digit;
            r_off_x  <= w_off_x_sel;
            r_off_y  <= w_off_y_sel;
        end
    end

    assign InsideRectangle = r_inside;
    assign digit           = r_digit;
    assign offsetX         = r_off_x;
    assign offsetY         = r_off_y;

endmodule
